// File: rtl/systolic_feeder_if.sv
// Bundle between the systolic feeder and whatever loads it and consumes its lanes.
// Also carries the feeder's FSM state and step counter for observation.
interface systolic_feeder_if #(
  parameter int WIDTH = 16,
  parameter int N     = 4
);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int T_W   = $clog2(3 * N - 2);

  // There is no ready: wr_en and go are single-cycle strobes sampled on a rising
  // edge and accepted only while busy=0; outside that window they are dropped.
  logic                 wr_en;
  logic                 wr_sel;
  logic [IDX_W-1:0]     wr_row;
  logic [IDX_W-1:0]     wr_col;
  logic [WIDTH-1:0]     wr_data;
  logic                 go;
  logic                 busy;
  logic                 done;
  logic                 start;
  logic [N*WIDTH-1:0]   west_out;
  logic [N*WIDTH-1:0]   north_out;
  logic [1:0]           dbg_state;
  logic [T_W-1:0]       dbg_t;

  modport master (
    output wr_en, wr_sel, wr_row, wr_col, wr_data, go,
    input  busy, done, start, west_out, north_out, dbg_state, dbg_t
  );

  modport slave (
    input  wr_en, wr_sel, wr_row, wr_col, wr_data, go,
    output busy, done, start, west_out, north_out, dbg_state, dbg_t
  );
endinterface

// File: rtl/systolic_feeder.sv
// Holds one A and one B operand and streams them, diagonally skewed, onto the
// west and north edges of an N x N systolic array while driving its start.
module systolic_feeder #(
  parameter int WIDTH = 16,
  parameter int N     = 4
) (
  input  logic            clk,
  input  logic            rst,
  systolic_feeder_if.slave bus
);
  localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
  localparam int T_W    = $clog2(3 * N - 2);
  localparam int T_LAST = 3 * N - 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FEED = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q;
  logic [T_W-1:0]     t_q;
  logic               start_q;
  logic               busy_q;
  logic               done_q;

  logic [WIDTH-1:0]   a_q [N][N];
  logic [WIDTH-1:0]   b_q [N][N];

  logic               wr_ok;
  logic [N*WIDTH-1:0] west_lane;
  logic [N*WIDTH-1:0] north_lane;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      t_q     <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.go) begin
            state_q <= FEED;
            t_q     <= '0;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        FEED: begin
          if (t_q == T_W'(T_LAST)) begin
            state_q <= DONE;
            start_q <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            t_q <= t_q + T_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          t_q     <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          t_q     <= '0;
          start_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Indices are widened by one bit so a non-power-of-two N can reject rows/cols >= N.
  assign wr_ok = bus.wr_en && (state_q == IDLE) &&
                 ({1'b0, bus.wr_row} < (IDX_W + 1)'(N)) &&
                 ({1'b0, bus.wr_col} < (IDX_W + 1)'(N));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          a_q[r][c] <= '0;
          b_q[r][c] <= '0;
        end
      end
    end else if (wr_ok) begin
      if (bus.wr_sel) begin
        b_q[bus.wr_row][bus.wr_col] <= bus.wr_data;
      end else begin
        a_q[bus.wr_row][bus.wr_col] <= bus.wr_data;
      end
    end
  end

  // Lane i is delayed by i steps so A[i][k] and B[k][j] meet at PE(i,j) at t=i+j+k.
  always_comb begin
    west_lane  = '0;
    north_lane = '0;
    if (state_q == FEED) begin
      for (int i = 0; i < N; i++) begin
        if ((t_q >= T_W'(i)) && ((t_q - T_W'(i)) < T_W'(N))) begin
          west_lane[i*WIDTH +: WIDTH]  = a_q[IDX_W'(i)][IDX_W'(t_q - T_W'(i))];
          north_lane[i*WIDTH +: WIDTH] = b_q[IDX_W'(t_q - T_W'(i))][IDX_W'(i)];
        end
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.start     = start_q;
  assign bus.west_out  = west_lane;
  assign bus.north_out = north_lane;
  assign bus.dbg_state = state_q;
  assign bus.dbg_t     = t_q;
endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench for systolic_feeder: expected lane words per feed step are queued
// when a job is launched and popped as start cycles appear; a PE-array model checks C.
module tb_systolic_feeder;
  localparam int W     = 16;
  localparam int N     = 4;
  localparam int LW    = 2 * N * W;
  localparam int STEPS = 3 * N - 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  bit   clk_run = 1'b0;

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  systolic_feeder_if #(.WIDTH(W), .N(N)) bus ();

  systolic_feeder #(.WIDTH(W), .N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [LW-1:0] exp_q[$];
  logic [W-1:0]  ma [N][N];
  logic [W-1:0]  mb [N][N];
  logic [W-1:0]  wh [STEPS][N];
  logic [W-1:0]  nh [STEPS][N];
  int            start_cnt;
  int            n_checks;
  int            n_errors;

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] exp_lanes(input int t);
    logic [N*W-1:0] w;
    logic [N*W-1:0] n;
    w = '0;
    n = '0;
    for (int i = 0; i < N; i++) begin
      if (t - i >= 0 && t - i < N) begin
        w[i*W +: W] = ma[i][t-i];
        n[i*W +: W] = mb[t-i][i];
      end
    end
    return {w, n};
  endfunction

  // Monitor: every start cycle consumes one expected lane pair.
  always @(negedge clk) begin
    if (bus.start === 1'b1) begin
      if (start_cnt < STEPS) begin
        for (int i = 0; i < N; i++) begin
          wh[start_cnt][i] = bus.west_out[i*W +: W];
          nh[start_cnt][i] = bus.north_out[i*W +: W];
        end
      end
      if (exp_q.size() == 0) begin
        check("sb_underflow", 1, 0);
      end else begin
        check($sformatf("lanes_t%0d", start_cnt), {bus.west_out, bus.north_out}, exp_q.pop_front());
      end
      start_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic write_word(input bit sel, input int row, input int col, input logic [W-1:0] data);
    @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.wr_sel  = sel;
    bus.wr_row  = row[1:0];
    bus.wr_col  = col[1:0];
    bus.wr_data = data;
    if (sel) mb[row][col] = data;
    else     ma[row][col] = data;
    @(posedge clk);
    #1 bus.wr_en = 1'b0;
  endtask

  task automatic clear_model();
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        ma[r][c] = '0;
        mb[r][c] = '0;
      end
    end
  endtask

  // Launch a job; optionally write B[0][0] on the go edge, re-pulse go / write A[0][0]
  // during feed at given steps, or pull rst at a given step.
  task automatic run_job(input bit same_wr, input logic [W-1:0] same_data,
                         input int go_at, input int wr_at, input int rst_at);
    int       cyc;
    bit       seen;
    longint   acc;
    longint   ref_c;
    logic [W-1:0] wv;
    logic [W-1:0] nv;
    if (same_wr) mb[0][0] = same_data;
    exp_q.delete();
    for (int t = 0; t < STEPS; t++) exp_q.push_back(exp_lanes(t));
    @(negedge clk);
    start_cnt = 0;
    bus.go    = 1'b1;
    if (same_wr) begin
      bus.wr_en   = 1'b1;
      bus.wr_sel  = 1'b1;
      bus.wr_row  = '0;
      bus.wr_col  = '0;
      bus.wr_data = same_data;
    end
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      bus.go    = 1'b0;
      bus.wr_en = 1'b0;
      if (bus.done === 1'b1) begin
        seen = 1'b1;
      end else begin
        if (cyc == go_at) bus.go = 1'b1;
        if (cyc == wr_at) begin
          bus.wr_en   = 1'b1;
          bus.wr_sel  = 1'b0;
          bus.wr_row  = '0;
          bus.wr_col  = '0;
          bus.wr_data = 16'hBEEF;
        end
        if (cyc == rst_at) begin
          #2 rst = 1'b1;
          #1;
          check("rst_start", bus.start, 0);
          check("rst_busy", bus.busy, 0);
          check("rst_done", bus.done, 0);
          check("rst_west", bus.west_out, 0);
          check("rst_north", bus.north_out, 0);
          check("rst_state", bus.dbg_state, 0);
          clear_model();
          exp_q.delete();
          @(negedge clk);
          rst = 1'b0;
          @(negedge clk);
          check("post_rst_state", bus.dbg_state, 0);
          check("post_rst_busy", bus.busy, 0);
          return;
        end
        cyc++;
      end
    end
    check("done_seen", seen, 1);
    check("done_step", cyc, STEPS);
    check("done_busy", bus.busy, 1);
    check("done_start", bus.start, 0);
    check("start_count", start_cnt, STEPS);
    check("sb_leftover", exp_q.size(), 0);
    // PE(i,j) sees lane i delayed by j and lane j delayed by i.
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        acc   = 0;
        ref_c = 0;
        for (int t = 0; t < STEPS; t++) begin
          wv = (t - j >= 0) ? wh[t-j][i] : '0;
          nv = (t - i >= 0) ? nh[t-i][j] : '0;
          acc += longint'(wv) * longint'(nv);
        end
        for (int k = 0; k < N; k++) ref_c += longint'(ma[i][k]) * longint'(mb[k][j]);
        check($sformatf("c_%0d_%0d", i, j), acc, ref_c);
      end
    end
    @(negedge clk);
    check("idle_busy", bus.busy, 0);
    check("idle_done", bus.done, 0);
    check("idle_start", bus.start, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    n_checks    = 0;
    n_errors    = 0;
    start_cnt   = 0;
    bus.wr_en   = 1'b0;
    bus.wr_sel  = 1'b0;
    bus.wr_row  = '0;
    bus.wr_col  = '0;
    bus.wr_data = '0;
    bus.go      = 1'b0;
    clear_model();

    rst = 1'b1;
    #3;
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_start", bus.start, 0);
    check("reset_west", bus.west_out, 0);
    check("reset_north", bus.north_out, 0);
    check("reset_state", bus.dbg_state, 0);
    check("reset_t", bus.dbg_t, 0);
    #2 clk_run = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Empty buffers.
    run_job(1'b0, '0, -1, -1, -1);

    // Identity x B.
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        write_word(1'b0, r, c, (r == c) ? 16'd1 : 16'd0);
        write_word(1'b1, r, c, W'(4 * r + c + 1));
      end
    end
    run_job(1'b0, '0, -1, -1, -1);
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) check($sformatf("ident_b_%0d_%0d", i, j), mb[i][j], 4 * i + j + 1);
    end

    // Skew pattern A[r][c] = 10r+c.
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) write_word(1'b0, r, c, W'(10 * r + c));
    end
    run_job(1'b0, '0, -1, -1, -1);

    // go at t=4 and A[0][0] write at t=5 must both be ignored.
    run_job(1'b0, '0, 4, 5, -1);

    // Same-edge write of B[0][0]=7 with go; also shows A[0][0] kept its value.
    run_job(1'b1, 16'd7, -1, -1, -1);

    // Reset mid-feed, then a job that must see cleared buffers.
    run_job(1'b0, '0, -1, -1, 5);
    run_job(1'b0, '0, -1, -1, -1);

    // Random operands.
    for (int rep = 0; rep < 2; rep++) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          write_word(1'b0, r, c, W'($urandom_range(0, 65535)));
          write_word(1'b1, r, c, W'($urandom_range(0, 65535)));
        end
      end
      run_job(1'b0, '0, -1, -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
